// File: rtl/scurve_multi_channel_counter.sv
// Multi-channel S-curve counter: counts CLK_EXT pulses and per-channel trigger edges inside the CLK_EXT-high window.
// Latency: SYNC_STAGES+1 Clk cycles from input to edge detection; CPT_DONE rises the cycle after the final qualifying ext_fall.
// Backpressure: none, free-running; Test_Start low aborts or releases a scan point, and results hold until the next ARM.
//
// Ports:
//   Clk, reset_n              - system clock, synchronous active-low reset
//   Trigger[NCH], CLK_EXT     - asynchronous inputs, synchronised internally
//   Test_Start                - level: high runs or holds a scan point, low aborts or releases
//   CPT_MAX, Trig_Edge,
//   Chan_Mask                 - scan configuration, captured while in ARM
//   Rd_Sel                    - selects the channel driven onto CPT_TRIGGER
//   CPT_PULSE, CPT_TRIGGER    - pulse count and the selected channel's trigger count
//   Trig_Ovf[NCH]             - sticky per-channel saturation flags
//   Busy, CPT_DONE            - Busy is high in ARM/COUNT; CPT_DONE is high in DONE
module scurve_multi_channel_counter #(
  parameter int NCH         = 4,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  localparam int SEL_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic [NCH-1:0]   Trigger,
  input  logic             CLK_EXT,
  input  logic             Test_Start,
  input  logic [CNT_W-1:0] CPT_MAX,
  input  logic             Trig_Edge,
  input  logic [NCH-1:0]   Chan_Mask,
  input  logic [SEL_W-1:0] Rd_Sel,
  output logic [CNT_W-1:0] CPT_PULSE,
  output logic [CNT_W-1:0] CPT_TRIGGER,
  output logic [NCH-1:0]   Trig_Ovf,
  output logic             Busy,
  output logic             CPT_DONE
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_COUNT, S_DONE} state_t;

  state_t state, state_nxt;

  // Synchronisers plus one delay flop for edge detection
  logic [SYNC_STAGES-1:0] ext_sync;
  logic                   ext_d;
  logic [NCH-1:0]         trg_sync [SYNC_STAGES];
  logic [NCH-1:0]         trg_d;

  logic                   ext_s, ext_rise, ext_fall;
  logic [NCH-1:0]         trg_s, trg_edge;

  // Scan configuration captured in ARM
  logic [CNT_W-1:0]       max_l;
  logic                   edge_l;
  logic [NCH-1:0]         mask_l;

  logic [CNT_W-1:0]       pulse_cnt;
  logic [CNT_W-1:0]       trg_cnt [NCH];
  logic [NCH-1:0]         trig_ovf;

  logic                   arm_clr;
  logic                   cnt_en;

  // Trigger flops reset to the inactive level of the selected edge so that
  // leaving reset never looks like a trigger edge.
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      ext_sync <= '0;
      ext_d    <= 1'b0;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        trg_sync[s] <= {NCH{~Trig_Edge}};
      end
      trg_d    <= {NCH{~Trig_Edge}};
    end else begin
      ext_sync    <= {ext_sync[SYNC_STAGES-2:0], CLK_EXT};
      ext_d       <= ext_s;
      trg_sync[0] <= Trigger;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        trg_sync[s] <= trg_sync[s-1];
      end
      trg_d       <= trg_s;
    end
  end

  assign ext_s    = ext_sync[SYNC_STAGES-1];
  assign trg_s    = trg_sync[SYNC_STAGES-1];
  assign ext_rise = ext_s & ~ext_d;
  assign ext_fall = ~ext_s & ext_d;
  // Edge polarity comes from the latched copy so a mid-scan change is ignored
  assign trg_edge = edge_l ? (trg_s & ~trg_d) : (~trg_s & trg_d);

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    arm_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (Test_Start) state_nxt = S_ARM;
      end
      S_ARM: begin
        arm_clr = 1'b1;
        // CPT_MAX is the value being latched this cycle, so it equals max_l
        // from the next cycle on.
        if (!Test_Start)          state_nxt = S_IDLE;
        else if (CPT_MAX == '0)   state_nxt = S_DONE;
        else if (!ext_s)          state_nxt = S_COUNT;
      end
      S_COUNT: begin
        if (!Test_Start) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_en = 1'b1;
          // Leave on the falling edge so the last window is counted in full
          if (ext_fall && (pulse_cnt >= max_l)) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (!Test_Start) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      pulse_cnt <= '0;
      trig_ovf  <= '0;
      max_l     <= '0;
      edge_l    <= 1'b0;
      mask_l    <= '0;
      for (int i = 0; i < NCH; i++) begin
        trg_cnt[i] <= '0;
      end
    end else if (arm_clr) begin
      pulse_cnt <= '0;
      trig_ovf  <= '0;
      max_l     <= CPT_MAX;
      edge_l    <= Trig_Edge;
      mask_l    <= Chan_Mask;
      for (int i = 0; i < NCH; i++) begin
        trg_cnt[i] <= '0;
      end
    end else if (cnt_en) begin
      if (ext_rise && (pulse_cnt < max_l)) begin
        pulse_cnt <= pulse_cnt + CNT_W'(1);
      end
      // ext_s gates the window: an edge with ext_rise counts, one with ext_fall does not
      for (int i = 0; i < NCH; i++) begin
        if (trg_edge[i] && ext_s && mask_l[i]) begin
          if (trg_cnt[i] == {CNT_W{1'b1}}) begin
            trig_ovf[i] <= 1'b1;
          end else begin
            trg_cnt[i] <= trg_cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Out-of-range selections match no channel and read as zero
  always_comb begin
    CPT_TRIGGER = '0;
    for (int i = 0; i < NCH; i++) begin
      if (Rd_Sel == SEL_W'(i)) CPT_TRIGGER = trg_cnt[i];
    end
  end

  assign CPT_PULSE = pulse_cnt;
  assign Trig_Ovf  = trig_ovf;
  assign Busy      = (state == S_ARM) || (state == S_COUNT);
  assign CPT_DONE  = (state == S_DONE);

endmodule

// File: tb/tb_scurve_multi_channel_counter.sv
// Directed bench for scurve_multi_channel_counter with a scoreboard of expected results.
// Latency: windows are 8 Clk high / 8 Clk low; results are compared after each scan point.
// Backpressure: none; every wait on the DUT is bounded by a cycle budget.
module tb_scurve_multi_channel_counter;

  localparam int NCH   = 4;
  localparam int CNT_W = 4;   // small so saturation is reachable in a short run
  localparam int SYNC  = 2;

  logic             Clk;
  logic             reset_n;
  logic [NCH-1:0]   Trigger;
  logic             CLK_EXT;
  logic             Test_Start;
  logic [CNT_W-1:0] CPT_MAX;
  logic             Trig_Edge;
  logic [NCH-1:0]   Chan_Mask;
  logic [1:0]       Rd_Sel;
  logic [CNT_W-1:0] CPT_PULSE;
  logic [CNT_W-1:0] CPT_TRIGGER;
  logic [NCH-1:0]   Trig_Ovf;
  logic             Busy;
  logic             CPT_DONE;

  scurve_multi_channel_counter #(.NCH(NCH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
    .Clk(Clk), .reset_n(reset_n), .Trigger(Trigger), .CLK_EXT(CLK_EXT),
    .Test_Start(Test_Start), .CPT_MAX(CPT_MAX), .Trig_Edge(Trig_Edge),
    .Chan_Mask(Chan_Mask), .Rd_Sel(Rd_Sel), .CPT_PULSE(CPT_PULSE),
    .CPT_TRIGGER(CPT_TRIGGER), .Trig_Ovf(Trig_Ovf), .Busy(Busy), .CPT_DONE(CPT_DONE)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // kind: 0 pulse, 1 trigger[ch], 2 ovf, 3 done, 4 busy
  typedef struct {
    int    kind;
    int    ch;
    int    exp;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model of the running scan point
  int   m_pulse, m_max, m_win;
  int   m_trg [NCH];
  logic [NCH-1:0] m_ovf, m_mask;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input int ch, input int exp, input string tag);
    exp_t e;
    e.kind = kind; e.ch = ch; e.exp = exp; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.kind == 1) Rd_Sel = 2'(e.ch);
      #1;
      case (e.kind)
        0:       obs = 32'(CPT_PULSE);
        1:       obs = 32'(CPT_TRIGGER);
        2:       obs = 32'(Trig_Ovf);
        3:       obs = 32'(CPT_DONE);
        default: obs = 32'(Busy);
      endcase
      check(e.tag, obs, 32'(e.exp));
    end
    @(negedge Clk);
  endtask

  task automatic push_scan(input string name, input int done_exp);
    push(0, 0, m_pulse, {name, "_pulse"});
    for (int c = 0; c < NCH; c++) push(1, c, m_trg[c], $sformatf("%s_trg%0d", name, c));
    push(2, 0, int'(m_ovf), {name, "_ovf"});
    push(3, 0, done_exp, {name, "_done"});
  endtask

  task automatic model_reset(input int max, input logic [NCH-1:0] mask);
    m_pulse = 0; m_max = max; m_win = 0; m_ovf = '0; m_mask = mask;
    for (int c = 0; c < NCH; c++) m_trg[c] = 0;
  endtask

  task automatic start_scan(input int max, input logic e, input logic [NCH-1:0] mask);
    CPT_MAX = CNT_W'(max); Trig_Edge = e; Chan_Mask = mask;
    Trigger = {NCH{~e}}; CLK_EXT = 1'b0;
    repeat (5) @(negedge Clk);
    Test_Start = 1'b1;
    repeat (4) @(negedge Clk);
    model_reset(max, mask);
  endtask

  task automatic stop_scan();
    Test_Start = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  // One CLK_EXT period: hp/hp2 give one-cycle trigger pulses in the high
  // half, lp in the low half. Each pulse leaves idle and returns, so it
  // contributes exactly one edge of the selected polarity.
  task automatic window(input logic [NCH-1:0] hp, input logic [NCH-1:0] hp2,
                        input logic [NCH-1:0] lp, input int done_w, input string name);
    m_win++;
    if (m_win <= m_max) begin
      m_pulse++;
      for (int c = 0; c < NCH; c++) begin
        if (m_mask[c]) begin
          for (int k = 0; k < int'(hp[c]) + int'(hp2[c]); k++) begin
            if (m_trg[c] == (1 << CNT_W) - 1) m_ovf[c] = 1'b1;
            else m_trg[c]++;
          end
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      case (i)
        0:  CLK_EXT = 1'b1;
        2, 3:   Trigger = Trigger ^ hp;
        4, 5:   Trigger = Trigger ^ hp2;
        8:  CLK_EXT = 1'b0;
        10, 11: Trigger = Trigger ^ lp;
        default: ;
      endcase
      if (m_win == done_w && i == 10) check({name, "_done_early"}, 32'(CPT_DONE), 32'd0);
      if (m_win == done_w && i == 11) check({name, "_done_rise"}, 32'(CPT_DONE), 32'd1);
      @(negedge Clk);
    end
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (CPT_DONE !== 1'b1 && k < 64) begin
      @(negedge Clk);
      k++;
    end
    check({name, "_done_wait"}, 32'(CPT_DONE), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; Trigger = '1; CLK_EXT = 1'b0; Test_Start = 1'b0;
    CPT_MAX = '0; Trig_Edge = 1'b0; Chan_Mask = '1; Rd_Sel = '0;
    repeat (3) @(negedge Clk);
    model_reset(0, '1);
    push_scan("rst", 0);
    push(4, 0, 0, "rst_busy");
    drain();
    reset_n = 1'b1;
    @(negedge Clk);

    // Basic scan: falling edges on ch0 in every window, ch2 only in the low half
    start_scan(10, 1'b0, 4'b1111);
    push(4, 0, 1, "s1_busy");
    drain();
    for (int w = 1; w <= 12; w++) window(4'b0001, 4'b0000, 4'b0100, 10, "s1");
    wait_done("s1");
    push_scan("s1", 1);
    push(4, 0, 0, "s1_busy_done");
    drain();
    stop_scan();
    push(3, 0, 0, "s1_idle_done");
    push(0, 0, 10, "s1_idle_pulse");
    drain();

    // Rising edges in the high half on ch2; Trig_Edge flipped mid-scan has no effect
    start_scan(6, 1'b1, 4'b1111);
    Trig_Edge = 1'b0;
    for (int w = 1; w <= 7; w++) window(4'b0100, 4'b0000, 4'b0001, 6, "s2");
    wait_done("s2");
    push_scan("s2", 1);
    drain();
    stop_scan();

    // Abort after 5 pulses, then restart from zero
    start_scan(10, 1'b0, 4'b1111);
    for (int w = 1; w <= 5; w++) window(4'b0010, 4'b0000, 4'b0000, -1, "s3");
    stop_scan();
    push_scan("s3_abort", 0);
    push(4, 0, 0, "s3_abort_busy");
    drain();
    start_scan(3, 1'b0, 4'b1111);
    push(0, 0, 0, "s3_rearm_pulse");
    push(1, 1, 0, "s3_rearm_trg1");
    drain();
    for (int w = 1; w <= 3; w++) window(4'b0010, 4'b0000, 4'b0000, 3, "s3b");
    wait_done("s3b");
    push_scan("s3b", 1);
    drain();
    stop_scan();

    // Saturation: two edges per window on ch3 -> 20 edges into a 4-bit counter
    start_scan(10, 1'b0, 4'b1111);
    for (int w = 1; w <= 10; w++) window(4'b1000, 4'b1000, 4'b0000, 10, "s4");
    wait_done("s4");
    push_scan("s4", 1);
    drain();
    stop_scan();

    // CPT_MAX=0: DONE within 2 cycles, overflow flags cleared by ARM
    CPT_MAX = '0; Trig_Edge = 1'b0; Chan_Mask = '1;
    Test_Start = 1'b1;
    repeat (2) @(negedge Clk);
    check("s5_done_fast", 32'(CPT_DONE), 32'd1);
    model_reset(0, '1);
    push_scan("s5", 1);
    drain();
    stop_scan();

    // Mask 0101 with triggers on all channels; mask change mid-scan ignored
    start_scan(4, 1'b0, 4'b0101);
    Chan_Mask = 4'b1111;
    for (int w = 1; w <= 5; w++) window(4'b1111, 4'b0000, 4'b0000, 4, "s6");
    wait_done("s6");
    push_scan("s6", 1);
    drain();
    stop_scan();

    // Start while CLK_EXT high: the partial window is dropped
    CPT_MAX = 4'd3; Trig_Edge = 1'b0; Chan_Mask = '1; Trigger = '1;
    CLK_EXT = 1'b1;
    repeat (4) @(negedge Clk);
    Test_Start = 1'b1;
    repeat (2) @(negedge Clk);
    check("s7_busy_arm", 32'(Busy), 32'd1);
    Trigger = Trigger ^ 4'b0001;
    @(negedge Clk);
    Trigger = Trigger ^ 4'b0001;
    repeat (2) @(negedge Clk);
    CLK_EXT = 1'b0;
    repeat (8) @(negedge Clk);
    model_reset(3, '1);
    for (int w = 1; w <= 3; w++) window(4'b0001, 4'b0000, 4'b0000, 3, "s7");
    wait_done("s7");
    push_scan("s7", 1);
    drain();
    stop_scan();

    // Synchronous reset in COUNT
    start_scan(10, 1'b0, 4'b1111);
    for (int w = 1; w <= 2; w++) window(4'b0001, 4'b0000, 4'b0000, -1, "s8");
    push(0, 0, 2, "s8_pre_pulse");
    push(1, 0, 2, "s8_pre_trg0");
    drain();
    reset_n = 1'b0;
    @(negedge Clk);
    model_reset(0, '1);
    push_scan("s8_rst", 0);
    push(4, 0, 0, "s8_rst_busy");
    drain();
    Test_Start = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
